// File: rtl/store_checker_pkg.sv
// Shared types and helpers for the store-sequence checker.
// Holds the FSM state encoding, the fail-cause codes and a width helper.
package store_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_BAD_ADDR = 3'd1,
    FC_BAD_DATA = 3'd2,
    FC_TIMEOUT  = 3'd3
  } fail_code_t;

  // Index width that stays at least one bit wide for a single-entry table.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/store_checker_table.sv
// Expected address/data table: one synchronous write port, one combinational
// read port, and an asynchronous clear of every entry.
module store_checker_table #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // NOTE: the table is built from flops rather than RAM because reset must
  // return every entry to zero; a RAM macro cannot be cleared this way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (we && (32'(wr_idx) < 32'(DEPTH))) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Out-of-range reads (only possible once the sequence is complete) return zero.
  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    if (32'(rd_idx) < 32'(DEPTH)) begin
      rd_addr = addr_mem[rd_idx];
      rd_data = data_mem[rd_idx];
    end
  end

endmodule

// File: rtl/store_checker.sv
// Store-sequence checker: compares each data-memory store against an ordered
// table of expected address/data pairs and reports pass, fail cause and timeout.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 1000,
  parameter bit STRICT_ADDR = 1'b1,
  parameter bit RETRY_DATA  = 1'b1,
  localparam int IDX_W      = clog2_min1(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  num_exp,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [31:0]       cyc_cnt
);

  localparam logic [31:0]      TO_LAST   = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_t           state_q, state_d;
  fail_code_t       fail_q, fail_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] nexp_q, nexp_d;
  logic [31:0]      cyc_q, cyc_d;

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              addr_hit, data_hit, timeout_hit;
  logic [CNT_W-1:0]  match_inc, num_clamped;

  store_checker_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (load_en && (state_q == IDLE)),
    .wr_idx  (load_idx),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_idx  (match_q[IDX_W-1:0]),
    .rd_addr (exp_addr),
    .rd_data (exp_data)
  );

  assign addr_hit    = (dataadr == exp_addr);
  assign data_hit    = (writedata == exp_data);
  assign match_inc   = match_q + 1'b1;
  assign num_clamped = (num_exp > DEPTH_CNT) ? DEPTH_CNT : num_exp;
  assign timeout_hit = (TIMEOUT != 0) && (cyc_q == TO_LAST);

  // NOTE: every variable gets its hold value before the case so no path
  // through this block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    match_d = match_q;
    nexp_d  = nexp_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE, PASS, FAIL: begin
        if (start) begin
          nexp_d  = num_clamped;
          match_d = '0;
          cyc_d   = '0;
          fail_d  = FC_NONE;
          state_d = (num_clamped == '0) ? PASS : RUN;
        end
      end
      RUN: begin
        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
        if (memwrite && addr_hit && data_hit) begin
          match_d = match_inc;
          if (match_inc == nexp_q) state_d = PASS;
        end else if (memwrite && addr_hit && !RETRY_DATA) begin
          state_d = FAIL;
          fail_d  = FC_BAD_DATA;
        end else if (memwrite && !addr_hit && STRICT_ADDR) begin
          state_d = FAIL;
          fail_d  = FC_BAD_ADDR;
        end
        // A final match on the timeout cycle has already moved us to PASS.
        if ((state_d == RUN) && timeout_hit) begin
          state_d = FAIL;
          fail_d  = FC_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fail_q  <= FC_NONE;
      match_q <= '0;
      nexp_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      match_q <= match_d;
      nexp_q  <= nexp_d;
      cyc_q   <= cyc_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == PASS) || (state_q == FAIL);
  assign pass      = (state_q == PASS);
  assign fail_code = fail_q;
  assign match_cnt = match_q;
  assign cyc_cnt   = cyc_q;

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench: three store_checker configurations driven with the same
// stimulus, each compared every cycle against a behavioural sequence model.
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, start, memwrite;
  logic [2:0]  load_idx, num_exp;
  logic [31:0] load_addr, load_data, dataadr, writedata;

  logic        bsy [3];
  logic        dn  [3];
  logic        ps  [3];
  logic [2:0]  fc  [3];
  logic [2:0]  mc  [3];
  logic [31:0] cc  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 0: defaults; 1: timeout 10, lenient address, strict data; 2: depth 5, no timeout
  store_checker #(.DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx[1:0]),
    .load_addr(load_addr), .load_data(load_data), .num_exp(num_exp), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .fail_code(fc[0]),
    .match_cnt(mc[0]), .cyc_cnt(cc[0]));

  store_checker #(.DEPTH(4), .TIMEOUT(10), .STRICT_ADDR(1'b0), .RETRY_DATA(1'b0)) u_b (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx[1:0]),
    .load_addr(load_addr), .load_data(load_data), .num_exp(num_exp), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .fail_code(fc[1]),
    .match_cnt(mc[1]), .cyc_cnt(cc[1]));

  store_checker #(.DEPTH(5), .TIMEOUT(0)) u_c (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_addr(load_addr), .load_data(load_data), .num_exp(num_exp), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .fail_code(fc[2]),
    .match_cnt(mc[2]), .cyc_cnt(cc[2]));

  // Per-configuration parameters as the model sees them
  int depth_p  [3] = '{4, 4, 5};
  int tmo_p    [3] = '{1000, 10, 0};
  bit strict_p [3] = '{1'b1, 1'b0, 1'b1};
  bit retry_p  [3] = '{1'b1, 1'b0, 1'b1};
  int idx_mask [3] = '{3, 3, 7};

  // Model: running / finished / passed flags, counts and the expected table
  bit          m_run  [3];
  bit          m_done [3];
  bit          m_pass [3];
  int          m_code [3];
  int          m_mcnt [3];
  int          m_nexp [3];
  longint      m_cyc  [3];
  logic [31:0] t_addr [3][8];
  logic [31:0] t_data [3][8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 0; m_done[k] = 0; m_pass[k] = 0;
      m_code[k] = 0; m_mcnt[k] = 0; m_nexp[k] = 0; m_cyc[k] = 0;
      for (int i = 0; i < 8; i++) begin
        t_addr[k][i] = '0;
        t_data[k][i] = '0;
      end
    end
  endfunction

  // One clock edge of the sequence rules, applied to the inputs held across it
  function automatic void model_edge();
    for (int k = 0; k < 3; k++) begin
      int idx, n, code;
      bit fin;
      idx = int'(load_idx) & idx_mask[k];
      if (!m_run[k] && !m_done[k] && load_en && idx < depth_p[k]) begin
        t_addr[k][idx] = load_addr;
        t_data[k][idx] = load_data;
      end
      if (!m_run[k]) begin
        if (start) begin
          n = (int'(num_exp) > depth_p[k]) ? depth_p[k] : int'(num_exp);
          m_nexp[k] = n; m_mcnt[k] = 0; m_cyc[k] = 0; m_code[k] = 0;
          m_run[k] = (n != 0); m_done[k] = (n == 0); m_pass[k] = (n == 0);
        end
      end else begin
        fin = 0;
        code = 0;
        if (memwrite) begin
          if (dataadr == t_addr[k][m_mcnt[k]]) begin
            if (writedata == t_data[k][m_mcnt[k]]) begin
              m_mcnt[k]++;
              fin = (m_mcnt[k] == m_nexp[k]);
            end else if (!retry_p[k]) code = 2;
          end else if (strict_p[k]) code = 1;
        end
        if (!fin && code == 0 && tmo_p[k] != 0 && m_cyc[k] == longint'(tmo_p[k] - 1)) code = 3;
        if (m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k]++;
        if (fin) begin
          m_run[k] = 0; m_done[k] = 1; m_pass[k] = 1;
        end else if (code != 0) begin
          m_run[k] = 0; m_done[k] = 1; m_pass[k] = 0; m_code[k] = code;
        end
      end
    end
  endfunction

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy[%0d]", k), 64'(bsy[k]), 64'(m_run[k]));
      check($sformatf("done[%0d]", k), 64'(dn[k]), 64'(m_done[k]));
      check($sformatf("pass[%0d]", k), 64'(ps[k]), 64'(m_pass[k]));
      check($sformatf("fail_code[%0d]", k), 64'(fc[k]), 64'(m_code[k]));
      check($sformatf("match_cnt[%0d]", k), 64'(mc[k]), 64'(m_mcnt[k]));
      check($sformatf("cyc_cnt[%0d]", k), 64'(cc[k]), 64'(m_cyc[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_all();
    load_en  = 1'b0;
    start    = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    cmp_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_idx = 3'(idx); load_addr = a; load_data = d;
    tick();
  endtask

  task automatic go(input int n);
    start = 1'b1; num_exp = 3'(n);
    tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] X = 32'h1111_1111, Y = 32'h2222_2222;
  localparam logic [31:0] Z = 32'h3333_3333, W = 32'h4444_4444;

  initial begin
    reset = 1'b0; load_en = 0; start = 0; memwrite = 0;
    load_idx = '0; num_exp = '0; load_addr = '0; load_data = '0;
    dataadr = '0; writedata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp_all();
    check("rst_done", 64'(dn[0]), 64'd0);
    reset = 1'b1;

    // Retried data then correct store
    load(0, 32'd80, 32'hFFFF_AAFA);
    go(1);
    store(32'd80, 32'h1234_5678);
    check("t1_wait_busy", 64'(bsy[0]), 64'd1);
    store(32'd80, 32'hFFFF_AAFA);
    check("t1_pass", 64'(ps[0]), 64'd1);
    check("t1_mcnt", 64'(mc[0]), 64'd1);
    check("t1_code", 64'(fc[0]), 64'd0);
    check("t1_baddata_code", 64'(fc[1]), 64'd2);
    check("t1_baddata_mcnt", 64'(mc[1]), 64'd0);

    // Wrong address after two matches
    do_reset();
    load(0, 32'd80, X); load(1, 32'd84, Y); load(2, 32'd88, Z);
    go(3);
    store(32'd80, X); store(32'd84, Y); store(32'd92, W);
    check("t2_code", 64'(fc[0]), 64'd1);
    check("t2_mcnt", 64'(mc[0]), 64'd2);
    check("t2_lenient_busy", 64'(bsy[1]), 64'd1);
    idle(7);
    check("t2_lenient_timeout", 64'(fc[1]), 64'd3);

    // Timeout exactly ten cycles after start
    go(2);
    store(32'd80, X);
    idle(8);
    check("t4_busy_c9", 64'(bsy[1]), 64'd1);
    idle(1);
    check("t4_code", 64'(fc[1]), 64'd3);
    check("t4_cyc", 64'(cc[1]), 64'd10);
    store(32'h999, 32'd0);
    // Final match on the timeout cycle
    go(2);
    idle(8);
    store(32'd80, X);
    store(32'd84, Y);
    check("t4_match_wins", 64'(ps[1]), 64'd1);
    check("t4_match_cyc", 64'(cc[1]), 64'd10);

    // Interleaved unrelated stores, then restart with retained table
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 32'h80 + 32'(4 * i), 32'hD0 + 32'(i));
    go(4);
    for (int i = 0; i < 4; i++) begin
      store(32'h1000 + 32'(4 * i), 32'(i));
      store(32'h80 + 32'(4 * i), 32'hD0 + 32'(i));
    end
    check("t5_pass", 64'(ps[1]), 64'd1);
    check("t5_mcnt", 64'(mc[1]), 64'd4);
    go(4);
    check("t5_rerun_busy", 64'(bsy[1]), 64'd1);
    check("t5_rerun_mcnt", 64'(mc[1]), 64'd0);
    for (int i = 0; i < 4; i++) store(32'h80 + 32'(4 * i), 32'hD0 + 32'(i));
    check("t5_retained_pass", 64'(ps[1]), 64'd1);

    // Reset mid-run, then cleared table and empty sequence
    go(4);
    store(32'h80, 32'hD0); store(32'h84, 32'hD1);
    check("t6_mid_mcnt", 64'(mc[0]), 64'd2);
    do_reset();
    check("t6_rst_busy", 64'(bsy[0]), 64'd0);
    check("t6_rst_mcnt", 64'(mc[0]), 64'd0);
    go(1);
    store(32'h0, 32'h0);
    check("t6_cleared_pass", 64'(ps[0]), 64'd1);
    go(0);
    check("t6_empty_pass", 64'(ps[0]), 64'd1);
    check("t6_empty_busy", 64'(bsy[0]), 64'd0);

    // Out-of-range index and clamped count
    do_reset();
    load(5, 32'hAA, 32'hBB);
    load(0, 32'h10, 32'h1);
    go(7);
    store(32'h10, 32'h1);
    store(32'hAA, 32'hBB);

    // Randomised rounds
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) == 0 || r == 0) do_reset();
      repeat (3) load($urandom_range(0, 7), 32'h40 + 32'(4 * $urandom_range(0, 7)),
                      32'($urandom_range(0, 3)));
      go($urandom_range(0, 7));
      repeat (14) begin
        int sel;
        sel = $urandom_range(0, 15);
        if (sel < 8 && m_mcnt[0] < 4) begin
          memwrite = 1'b1;
          dataadr = t_addr[0][m_mcnt[0]];
          writedata = (sel == 0) ? 32'($urandom_range(0, 3)) : t_data[0][m_mcnt[0]];
        end else if (sel < 12) begin
          memwrite = 1'b1;
          dataadr = 32'h40 + 32'(4 * $urandom_range(0, 7));
          writedata = 32'($urandom_range(0, 3));
        end
        if (sel == 13) begin
          start = 1'b1; num_exp = 3'($urandom_range(0, 7));
        end
        if (sel == 14) begin
          load_en = 1'b1; load_idx = 3'($urandom_range(0, 7));
          load_addr = 32'h40; load_data = 32'd0;
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_checker.md
# store_checker

Parametrised, synthesizable store-sequence checker that watches the processor data-memory write port (`memwrite`, `dataadr`, `writedata`). It compares each store against a loaded table of expected address/data pairs, in order. It reports pass, fail and the fail cause, with a cycle timeout. It sits beside `top` in simulation and FPGA self-test builds, and replaces hard-coded single-store checks with a DEPTH-entry, mode-selectable checker.

## Interface

Parameters:
- ADDR_W, 32, width of `dataadr` and of expected addresses
- DATA_W, 32, width of `writedata` and of expected data
- DEPTH, 4, expected-table entries (≥1); IDX_W = $clog2(DEPTH) with a minimum of 1, CNT_W = $clog2(DEPTH+1)
- TIMEOUT, 1000, max cycles in RUN before failing; 0 disables the timeout
- STRICT_ADDR, 1, 1: a store to any address other than the current expected one is a failure; 0: such stores are ignored
- RETRY_DATA, 1, 1: a store to the expected address with wrong data is ignored and the checker keeps waiting; 0: it is a failure

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_en  in  1  write table entry; honoured only in IDLE
- load_idx  in  IDX_W  entry index
- load_addr  in  ADDR_W  expected address
- load_data  in  DATA_W  expected data
- num_exp  in  CNT_W  number of valid entries; sampled on start
- start  in  1  begin a check
- memwrite  in  1  store strobe
- dataadr  in  ADDR_W  store address
- writedata  in  DATA_W  store data
- busy  out  1  state==RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state==PASS
- fail_code  out  3  0 NONE, 1 BAD_ADDR, 2 BAD_DATA, 3 TIMEOUT
- match_cnt  out  CNT_W  entries matched so far
- cyc_cnt  out  32  cycles spent in RUN (saturates)

## Operation

- States: IDLE, RUN, PASS, FAIL.
- In IDLE, `load_en` writes the table entry at the next edge. `load_idx` ≥ DEPTH is ignored.
- From IDLE, PASS or FAIL, `start`:
  - latches `num_exp`, clamped to DEPTH;
  - clears match_cnt, cyc_cnt and fail_code;
  - enters RUN. If the latched count is 0, it enters PASS instead.
- The table is retained across start.
- In RUN, each edge with memwrite=1 is evaluated against entry[match_cnt]:
  - address and data both equal: match_cnt+1. If the new value equals the latched count, go to PASS.
  - address equal, data not equal: if RETRY_DATA, no effect; otherwise go to FAIL with code 2.
  - address not equal: if STRICT_ADDR, go to FAIL with code 1; otherwise no effect.
- Comparisons are exact 2-state equality over the full width. X/Z on inputs is never a match.
- Timeout: if TIMEOUT≠0 and cyc_cnt reaches TIMEOUT−1 in a RUN cycle that does not complete the sequence, go to FAIL with code 3.
- Simultaneous final match and timeout: the match wins, and the result is PASS.
- PASS and FAIL hold until start or reset. Stores in these states are ignored.
- `start` during RUN is ignored.
- `load_en` outside IDLE is ignored.

## Timing

- Reset (asynchronous assert, synchronous release):
  - state=IDLE;
  - busy, done, pass = 0;
  - fail_code=0, match_cnt=0, cyc_cnt=0;
  - table entries cleared to 0; latched count=0.
- Reset mid-RUN aborts immediately, with no pass/fail reported.
- start sampled at edge N: busy=1 from edge N. A store presented in the same cycle as start is not evaluated.
- Store evaluation latency is 1 cycle. A matching store at edge N updates match_cnt after edge N. On the final match, done and pass are 1 after edge N.
- Back-to-back stores on consecutive cycles each advance the sequence.
- cyc_cnt increments on every RUN edge and saturates at 2^32−1.
- All outputs are registered, with no combinational input→output paths.

## Structure

- Package `store_checker_pkg`:
  - `state_t` enum (IDLE, RUN, PASS, FAIL);
  - `fail_code_t` 3-bit enum (NONE, BAD_ADDR, BAD_DATA, TIMEOUT).
- Sub-module `store_checker_table`:
  - DEPTH×(ADDR_W+DATA_W) register array;
  - write port `load_en`/`load_idx`, combinational read at `match_cnt`;
  - async active-low clear.
- The top holds the FSM, the counters and the comparators.

## Test plan

- Defaults, table {80:0xFFFFAAFA}, num_exp=1, start, then store (80, 0x12345678) followed by (80, 0xFFFFAAFA) -> first store ignored; pass=1 one cycle after the second store; match_cnt=1; fail_code=0.
- Defaults, table {80:X, 84:Y, 88:Z}, stores 80:X, 84:Y, 92:W -> FAIL, fail_code=1, match_cnt=2.
- RETRY_DATA=0, table {80:0xA5}, store 80:0x5A -> FAIL, fail_code=2, match_cnt=0.
- TIMEOUT=10, num_exp=2, one matching store then idle -> FAIL code 3 exactly 10 cycles after start, cyc_cnt=10. Repeat with the final match landing on cycle 10 -> PASS.
- STRICT_ADDR=0, DEPTH=4, all four entries interleaved with stores to unrelated addresses -> PASS, match_cnt=4. Pulse start again -> RUN with counters cleared and table retained.
- Assert reset mid-RUN after 2 matches -> IDLE with all outputs 0 and the table cleared. num_exp=0 then start -> pass=1 on the next cycle.
